// File: rtl/aes_spi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_spi_pkg : shared types and helpers for the AES SPI scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
package aes_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_RECV = 3'd3,
    ST_DONE = 3'd4
  } spi_state_t;

  typedef enum logic {
    GNT_ENC = 1'b0,
    GNT_DEC = 1'b1
  } grant_t;

  localparam int BLOCK_W = 128;

  function automatic int frame_len(input int nk);
    return BLOCK_W + nk * 32;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_shift_engine : parallel-load MSB-first frame shifter and 128-bit capture
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_shift_engine
  import aes_spi_pkg::*;
#(
  parameter int FRAME = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 shift_out_i,
  input  logic                 shift_in_i,
  input  logic [FRAME-1:0]     frame_i,
  input  logic                 miso_i,
  output logic                 mosi_o,
  output logic [BLOCK_W-1:0]   capture_o
);

  logic [FRAME-1:0]   frame_q;
  logic               mosi_q;
  logic [BLOCK_W-1:0] cap_q;

  // The MSB goes straight to mosi on load so it appears in the first SEND cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
      mosi_q  <= 1'b0;
      cap_q   <= '0;
    end else begin
      if (load_i) begin
        mosi_q  <= frame_i[FRAME-1];
        frame_q <= {frame_i[FRAME-2:0], 1'b0};
      end else if (shift_out_i) begin
        mosi_q  <= frame_q[FRAME-1];
        frame_q <= {frame_q[FRAME-2:0], 1'b0};
      end else begin
        mosi_q  <= 1'b0;
      end
      if (shift_in_i) begin
        cap_q <= {cap_q[BLOCK_W-2:0], miso_i};
      end
    end
  end

  assign mosi_o    = mosi_q;
  assign capture_o = cap_q;

endmodule
`default_nettype wire

// File: rtl/aes_spi_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_spi_scheduler : round-robin sharing of one serial AES link enc/dec
// Rev 1.0
// ---------------------------------------------------------------------------
module aes_spi_scheduler
  import aes_spi_pkg::*;
#(
  parameter int NK  = 4,
  parameter int GAP = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_enc_i,
  input  logic                 req_dec_i,
  input  logic [BLOCK_W-1:0]   data_enc_i,
  input  logic [BLOCK_W-1:0]   data_dec_i,
  input  logic [NK*32-1:0]     key_enc_i,
  input  logic [NK*32-1:0]     key_dec_i,
  output logic                 ack_enc_o,
  output logic                 ack_dec_o,
  output logic                 done_enc_o,
  output logic                 done_dec_o,
  output logic [BLOCK_W-1:0]   result_o,
  output logic                 busy_o,
  output logic                 cs_enc_o,
  output logic                 cs_dec_o,
  output logic                 mosi_o,
  input  logic                 miso_i
);

  localparam int            FRAME     = frame_len(NK);
  localparam int            CW        = $clog2(FRAME);
  localparam logic [CW-1:0] SEND_LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(GAP - 1);
  localparam logic [CW-1:0] RECV_LAST = CW'(BLOCK_W - 1);

  spi_state_t         state_q;
  logic [CW-1:0]      cnt_q;
  grant_t             last_grant_q;
  logic               ack_enc_q, ack_dec_q;
  logic               done_enc_q, done_dec_q;
  logic               cs_enc_q, cs_dec_q;
  logic [BLOCK_W-1:0] result_q;

  grant_t             gnt_d;
  logic               any_req;
  logic               load, shift_out, shift_in;
  logic [FRAME-1:0]   frame_d;
  logic [BLOCK_W-1:0] capture;

  assign any_req = req_enc_i | req_dec_i;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    gnt_d = GNT_DEC;
    if (req_enc_i && req_dec_i) begin
      if (last_grant_q == GNT_DEC) gnt_d = GNT_ENC;
      else                         gnt_d = GNT_DEC;
    end else if (req_enc_i) begin
      gnt_d = GNT_ENC;
    end
  end

  assign frame_d   = (gnt_d == GNT_ENC) ? {data_enc_i, key_enc_i} : {data_dec_i, key_dec_i};
  assign load      = (state_q == ST_IDLE) && any_req;
  assign shift_out = (state_q == ST_SEND) && (cnt_q != SEND_LAST);
  assign shift_in  = (state_q == ST_RECV);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= GNT_DEC;
      ack_enc_q    <= 1'b0;
      ack_dec_q    <= 1'b0;
      done_enc_q   <= 1'b0;
      done_dec_q   <= 1'b0;
      cs_enc_q     <= 1'b0;
      cs_dec_q     <= 1'b0;
      result_q     <= '0;
    end else begin
      ack_enc_q  <= 1'b0;
      ack_dec_q  <= 1'b0;
      done_enc_q <= 1'b0;
      done_dec_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            state_q      <= ST_SEND;
            cnt_q        <= '0;
            last_grant_q <= gnt_d;
            ack_enc_q    <= (gnt_d == GNT_ENC);
            ack_dec_q    <= (gnt_d == GNT_DEC);
            cs_enc_q     <= (gnt_d == GNT_ENC);
            cs_dec_q     <= (gnt_d == GNT_DEC);
          end
        end
        ST_SEND: begin
          if (cnt_q == SEND_LAST) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            state_q <= ST_RECV;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RECV: begin
          if (cnt_q == RECV_LAST) begin
            state_q  <= ST_DONE;
            cnt_q    <= '0;
            cs_enc_q <= 1'b0;
            cs_dec_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          result_q   <= capture;
          done_enc_q <= (last_grant_q == GNT_ENC);
          done_dec_q <= (last_grant_q == GNT_DEC);
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  spi_shift_engine #(
    .FRAME (FRAME)
  ) u_engine (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .shift_out_i (shift_out),
    .shift_in_i  (shift_in),
    .frame_i     (frame_d),
    .miso_i      (miso_i),
    .mosi_o      (mosi_o),
    .capture_o   (capture)
  );

  assign ack_enc_o  = ack_enc_q;
  assign ack_dec_o  = ack_dec_q;
  assign done_enc_o = done_enc_q;
  assign done_dec_o = done_dec_q;
  assign result_o   = result_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign cs_enc_o   = cs_enc_q;
  assign cs_dec_o   = cs_dec_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_spi_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_aes_spi_scheduler : scoreboard bench with SPI slave model, two configs
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_aes_spi_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         sel = 1'b0;
  logic         req_enc = 1'b0, req_dec = 1'b0;
  logic [127:0] data_enc = '0, data_dec = '0;
  logic [255:0] key_enc = '0, key_dec = '0;
  logic         miso = 1'b0;

  logic         a_enc0, a_dec0, d_enc0, d_dec0, busy0, cse0, csd0, mosi0;
  logic         a_enc1, a_dec1, d_enc1, d_dec1, busy1, cse1, csd1, mosi1;
  logic [127:0] res0, res1;

  aes_spi_scheduler #(.NK(4), .GAP(12)) d0 (
    .clk(clk), .rst(rst),
    .req_enc_i(req_enc & ~sel), .req_dec_i(req_dec & ~sel),
    .data_enc_i(data_enc), .data_dec_i(data_dec),
    .key_enc_i(key_enc[127:0]), .key_dec_i(key_dec[127:0]),
    .ack_enc_o(a_enc0), .ack_dec_o(a_dec0), .done_enc_o(d_enc0), .done_dec_o(d_dec0),
    .result_o(res0), .busy_o(busy0), .cs_enc_o(cse0), .cs_dec_o(csd0),
    .mosi_o(mosi0), .miso_i(miso)
  );

  aes_spi_scheduler #(.NK(8), .GAP(1)) d1 (
    .clk(clk), .rst(rst),
    .req_enc_i(req_enc & sel), .req_dec_i(req_dec & sel),
    .data_enc_i(data_enc), .data_dec_i(data_dec),
    .key_enc_i(key_enc), .key_dec_i(key_dec),
    .ack_enc_o(a_enc1), .ack_dec_o(a_dec1), .done_enc_o(d_enc1), .done_dec_o(d_dec1),
    .result_o(res1), .busy_o(busy1), .cs_enc_o(cse1), .cs_dec_o(csd1),
    .mosi_o(mosi1), .miso_i(miso)
  );

  wire         m_ack_enc  = sel ? a_enc1 : a_enc0;
  wire         m_ack_dec  = sel ? a_dec1 : a_dec0;
  wire         m_done_enc = sel ? d_enc1 : d_enc0;
  wire         m_done_dec = sel ? d_dec1 : d_dec0;
  wire         m_cs_enc   = sel ? cse1 : cse0;
  wire         m_cs_dec   = sel ? csd1 : csd0;
  wire         m_mosi     = sel ? mosi1 : mosi0;
  wire         m_busy     = sel ? busy1 : busy0;
  wire [127:0] m_result   = sel ? res1 : res0;

  typedef struct {
    bit           dec;
    logic [383:0] frame;
    logic [127:0] resp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   flen     = 256;
  int   gap      = 12;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, expv);
  endtask

  // Slave model and monitor: captures mosi, drives miso, scores each done.
  int           cs_cnt = 0;
  int           ack_cyc = 0;
  int           done_cnt = 0;
  logic [383:0] got = '0;
  logic [1:0]   side_err = '0;
  logic         overlap = 1'b0;
  logic [127:0] rv;
  exp_t         mon_e;

  always @(negedge clk) begin
    if (m_cs_enc && m_cs_dec) overlap = 1'b1;
    if (m_ack_enc || m_ack_dec) begin
      if (exp_q.size() == 0) chk("unexpected_ack", 1, 0);
      else                   chk("ack_who", m_ack_dec, exp_q[0].dec);
      ack_cyc  = cyc;
      cs_cnt   = 0;
      got      = '0;
      side_err = '0;
    end
    if (m_cs_enc || m_cs_dec) begin
      if (exp_q.size() != 0 && m_cs_dec != exp_q[0].dec) side_err[0] = 1'b1;
      if (cs_cnt < flen) begin
        got[flen-1-cs_cnt] = m_mosi;
      end else if (cs_cnt < flen + gap) begin
        if (m_mosi) side_err[1] = 1'b1;
      end else if (cs_cnt < flen + gap + 128 && exp_q.size() != 0) begin
        rv   = exp_q[0].resp;
        miso = rv[127-(cs_cnt-flen-gap)];
      end
      cs_cnt++;
    end else begin
      miso = 1'b0;
    end
    if (m_done_enc || m_done_dec) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_who", m_done_dec, mon_e.dec);
        chk("latency", cyc - ack_cyc, 1 + flen + gap + 128);
        chk("frame", got, mon_e.frame);
        chk("result", m_result, mon_e.resp);
        chk("cs_len", cs_cnt, flen + gap + 128);
        chk("cs_sel_wait_mosi", side_err, 0);
      end
    end
  end

  task automatic push(input bit s, input bit dec, input logic [127:0] d,
                      input logic [255:0] k, input logic [127:0] r);
    exp_t e;
    e.dec  = dec;
    e.resp = r;
    if (s) e.frame = {d, k};
    else   e.frame = {256'b0, d, k[127:0]};
    exp_q.push_back(e);
  endtask

  task automatic do_req(input bit s, input bit dec, input logic [127:0] d,
                        input logic [255:0] k, input logic [127:0] r, input bit mutate);
    bit got_ack = 1'b0;
    push(s, dec, d, k, r);
    if (dec) begin data_dec = d; key_dec = k; req_dec = 1'b1; end
    else     begin data_enc = d; key_enc = k; req_enc = 1'b1; end
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (m_ack_enc || m_ack_dec) begin got_ack = 1'b1; break; end
    end
    req_enc = 1'b0;
    req_dec = 1'b0;
    if (!got_ack) chk("ack_timeout", 0, 1);
    if (mutate) begin
      @(negedge clk);
      data_enc = ~d;
      key_enc  = ~k;
    end
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  int acks;
  int ack1_cyc, ack2_cyc;
  int done_before;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_d0", {a_enc0, a_dec0, d_enc0, d_dec0, cse0, csd0, mosi0, busy0, res0}, 0);
    chk("reset_d1", {a_enc1, a_dec1, d_enc1, d_dec1, cse1, csd1, mosi1, busy1, res1}, 0);

    // Single encrypt with the known AES-128 vector.
    do_req(0, 0, 128'h00112233445566778899aabbccddeeff,
           {128'b0, 128'h000102030405060708090a0b0c0d0e0f},
           128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);
    drain(1000);

    // Inputs altered one cycle after ack must not reach the wire.
    do_req(0, 0, 128'hdeadbeef_01234567_89abcdef_cafef00d,
           {128'b0, 128'h0f0e0d0c0b0a09080706050403020100},
           128'h5555aaaa_3333cccc_0f0f0f0f_ffff0000, 1);
    drain(1000);

    // Tie straight after reset, both held for four grants.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    data_enc = 128'h11111111_22222222_33333333_44444444;
    key_enc  = {128'b0, 128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd};
    data_dec = 128'h99999999_88888888_77777777_66666666;
    key_dec  = {128'b0, 128'h12345678_9abcdef0_0fedcba9_87654321};
    push(0, 0, data_enc, key_enc, 128'h0123456789abcdef0123456789abcdef);
    push(0, 1, data_dec, key_dec, 128'hfedcba9876543210fedcba9876543210);
    push(0, 0, data_enc, key_enc, 128'h80000000000000000000000000000001);
    push(0, 1, data_dec, key_dec, 128'h00000000ffffffff00000000ffffffff);
    req_enc = 1'b1;
    req_dec = 1'b1;
    acks = 0;
    ack1_cyc = 0;
    ack2_cyc = 0;
    for (int i = 0; i < 3000 && acks < 4; i++) begin
      @(negedge clk);
      if (m_ack_enc || m_ack_dec) begin
        acks++;
        if (acks == 1) ack1_cyc = cyc;
        if (acks == 2) ack2_cyc = cyc;
      end
    end
    req_enc = 1'b0;
    req_dec = 1'b0;
    chk("fair_acks", acks, 4);
    chk("b2b_spacing", ack2_cyc - ack1_cyc, 1 + flen + gap + 128 + 1);
    drain(1000);

    // Reset during SEND cycle 100.
    do_req(0, 0, 128'hffeeddccbbaa99887766554433221100,
           {128'b0, 128'hf0e0d0c0b0a090807060504030201000}, 128'h1, 0);
    done_before = done_cnt;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_state", {cse0, csd0, busy0, res0}, 0);
    exp_q.delete();
    repeat (600) @(negedge clk);
    chk("abort_no_done", done_cnt - done_before, 0);
    do_req(0, 1, 128'h0badc0de_0badc0de_0badc0de_0badc0de,
           {128'b0, 128'h13579bdf_2468ace0_13579bdf_2468ace0},
           128'hc3c3c3c3_3c3c3c3c_a5a5a5a5_5a5a5a5a, 0);
    drain(1000);

    // Nk=8, GAP=1 configuration, key LSB set so the last frame bit is a 1.
    sel  = 1'b1;
    flen = 384;
    gap  = 1;
    @(negedge clk);
    do_req(1, 1, 128'h00112233445566778899aabbccddeeff,
           256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
           128'h8ea2b7ca516745bfeafc49904b496089, 0);
    drain(1500);
    chk("key_lsb_last", got[0], key_dec[0]);

    chk("cs_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
